// File: rtl/spi_reg_controller.sv
`default_nettype none
// ============================================================================
// spi_reg_controller
// Splits each SPI word stream into a header plus a burst of register writes or reads.
// Rev 1.0
// ============================================================================

module spi_reg_controller #(
   parameter int NUM_REGS = 65,
   parameter int ADDR_W   = 7
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              ssel_active,
   input  logic              word_valid,
   input  logic [15:0]       rx_word,
   output logic              reg_we,
   output logic [ADDR_W-1:0] reg_waddr,
   output logic [15:0]       reg_wdata,
   output logic              reg_re,
   output logic [ADDR_W-1:0] reg_raddr,
   input  logic [15:0]       reg_rdata,
   output logic [15:0]       tx_word,
   output logic              tx_load,
   output logic              busy,
   output logic              err
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WRITE    = 3'd1,
      ST_RD_FETCH = 3'd2,
      ST_RD_LOAD  = 3'd3,
      ST_RD_WAIT  = 3'd4
   } state_t;

   localparam logic [ADDR_W:0]   c_num_regs  = (ADDR_W+1)'(NUM_REGS);
   localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(NUM_REGS - 1);

   state_t              r_state;
   logic [ADDR_W-1:0]   r_addr;
   logic [6:0]          r_count;
   logic                r_err;
   logic                r_reg_we;
   logic [ADDR_W-1:0]   r_reg_waddr;
   logic [15:0]         r_reg_wdata;
   logic                r_reg_re;
   logic [ADDR_W-1:0]   r_reg_raddr;
   logic [15:0]         r_tx_word;
   logic                r_tx_load;

   logic [ADDR_W-1:0]   w_hdr_addr;
   logic                w_hdr_bad;
   logic [ADDR_W-1:0]   w_addr_inc;
   logic                w_unused_rsvd;

   assign w_hdr_addr    = rx_word[ADDR_W-1:0];
   assign w_hdr_bad     = ({1'b0, w_hdr_addr} >= c_num_regs);
   assign w_unused_rsvd = rx_word[7];

   // The bank is not a power of two deep, so the top address wraps explicitly.
   assign w_addr_inc = (r_addr == c_last_addr) ? '0 : r_addr + ADDR_W'(1);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_count     <= '0;
         r_err       <= 1'b0;
         r_reg_we    <= 1'b0;
         r_reg_waddr <= '0;
         r_reg_wdata <= '0;
         r_reg_re    <= 1'b0;
         r_reg_raddr <= '0;
         r_tx_word   <= '0;
         r_tx_load   <= 1'b0;
      end else begin
         r_reg_we  <= 1'b0;
         r_reg_re  <= 1'b0;
         r_tx_load <= 1'b0;

         if (!ssel_active) begin
            r_state <= ST_IDLE;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (word_valid) begin
                     r_addr  <= w_hdr_addr;
                     r_count <= rx_word[14:8];
                     r_err   <= w_hdr_bad;
                     r_state <= rx_word[15] ? ST_WRITE : ST_RD_FETCH;
                  end
               end

               ST_WRITE: begin
                  if (word_valid) begin
                     if (!r_err) begin
                        r_reg_we    <= 1'b1;
                        r_reg_waddr <= r_addr;
                        r_reg_wdata <= rx_word;
                     end
                     if (r_count == 7'd0) begin
                        r_state <= ST_IDLE;
                     end else begin
                        r_count <= r_count - 7'd1;
                        r_addr  <= w_addr_inc;
                     end
                  end
               end

               ST_RD_FETCH: begin
                  if (!r_err) begin
                     r_reg_re    <= 1'b1;
                     r_reg_raddr <= r_addr;
                  end
                  r_state <= ST_RD_LOAD;
               end

               ST_RD_LOAD: begin
                  // An out-of-range burst still feeds the shifter, with zeros.
                  r_tx_word <= r_err ? 16'h0000 : reg_rdata;
                  r_tx_load <= 1'b1;
                  r_state   <= ST_RD_WAIT;
               end

               ST_RD_WAIT: begin
                  if (word_valid) begin
                     if (r_count == 7'd0) begin
                        r_state <= ST_IDLE;
                     end else begin
                        r_count <= r_count - 7'd1;
                        r_addr  <= w_addr_inc;
                        r_state <= ST_RD_FETCH;
                     end
                  end
               end

               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign reg_we    = r_reg_we;
   assign reg_waddr = r_reg_waddr;
   assign reg_wdata = r_reg_wdata;
   assign reg_re    = r_reg_re;
   assign reg_raddr = r_reg_raddr;
   assign tx_word   = r_tx_word;
   assign tx_load   = r_tx_load;
   assign busy      = (r_state != ST_IDLE);
   assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_controller.sv
`default_nettype none
// ============================================================================
// tb_spi_reg_controller
// Scoreboard bench: stimulus queues expected strobes, a monitor pops and compares.
// Rev 1.0
// ============================================================================

module tb_spi_reg_controller;

   logic        sys_clk     = 1'b0;
   logic        sys_rst     = 1'b1;
   logic        ssel_active = 1'b1;
   logic        word_valid  = 1'b0;
   logic [15:0] rx_word     = 16'h0000;
   logic        reg_we;
   logic [6:0]  reg_waddr;
   logic [15:0] reg_wdata;
   logic        reg_re;
   logic [6:0]  reg_raddr;
   logic [15:0] reg_rdata;
   logic [15:0] tx_word;
   logic        tx_load;
   logic        busy;
   logic        err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int k     = 0;

   typedef struct {
      int          cyc;
      logic [6:0]  addr;
      logic [15:0] data;
   } exp_t;

   exp_t q_we[$];
   exp_t q_re[$];
   exp_t q_tx[$];

   spi_reg_controller #(.NUM_REGS(65), .ADDR_W(7)) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .ssel_active (ssel_active),
      .word_valid  (word_valid),
      .rx_word     (rx_word),
      .reg_we      (reg_we),
      .reg_waddr   (reg_waddr),
      .reg_wdata   (reg_wdata),
      .reg_re      (reg_re),
      .reg_raddr   (reg_raddr),
      .reg_rdata   (reg_rdata),
      .tx_word     (tx_word),
      .tx_load     (tx_load),
      .busy        (busy),
      .err         (err)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   // Asynchronous-read register bank model: recognisable content per address.
   assign reg_rdata = 16'hA500 | {9'd0, reg_raddr};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic exp_we(input int c, input logic [6:0] a, input logic [15:0] d);
      q_we.push_back('{c, a, d});
   endtask

   task automatic exp_rd(input int c, input logic [6:0] a, input logic [15:0] d);
      q_re.push_back('{c + 1, a, 16'h0000});
      q_tx.push_back('{c + 2, 7'd0, d});
   endtask

   // Drives a word so it is sampled at the next rising edge; k is that edge's cycle.
   task automatic present(input logic [15:0] w);
      @(negedge sys_clk);
      word_valid = 1'b1;
      rx_word    = w;
      k          = cyc + 1;
   endtask

   task automatic drop();
      @(negedge sys_clk);
      word_valid = 1'b0;
   endtask

   task automatic gap();
      repeat (4) @(negedge sys_clk);
   endtask

   task automatic send(input logic [15:0] w);
      present(w);
      drop();
      gap();
   endtask

   // Monitor: every strobe must match the oldest expectation, including its cycle.
   always @(posedge sys_clk) begin
      exp_t e;
      #1;
      if (reg_we) begin
         if (q_we.size() == 0) begin
            total++; bad++;
            $display("FAIL we_unexpected: got addr=%0d data=%h want no write", reg_waddr, reg_wdata);
         end else begin
            e = q_we.pop_front();
            check("we_cycle", cyc, e.cyc);
            check("we_addr", {25'd0, reg_waddr}, {25'd0, e.addr});
            check("we_data", {16'd0, reg_wdata}, {16'd0, e.data});
         end
      end
      if (reg_re) begin
         if (q_re.size() == 0) begin
            total++; bad++;
            $display("FAIL re_unexpected: got addr=%0d want no read", reg_raddr);
         end else begin
            e = q_re.pop_front();
            check("re_cycle", cyc, e.cyc);
            check("re_addr", {25'd0, reg_raddr}, {25'd0, e.addr});
         end
      end
      if (tx_load) begin
         if (q_tx.size() == 0) begin
            total++; bad++;
            $display("FAIL tx_unexpected: got word=%h want no load", tx_word);
         end else begin
            e = q_tx.pop_front();
            check("tx_cycle", cyc, e.cyc);
            check("tx_word", {16'd0, tx_word}, {16'd0, e.data});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge sys_clk);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_err", {31'd0, err}, 0);
      check("rst_we", {31'd0, reg_we}, 0);
      check("rst_re", {31'd0, reg_re}, 0);
      check("rst_tx_load", {31'd0, tx_load}, 0);
      check("rst_tx_word", {16'd0, tx_word}, 0);
      sys_rst = 1'b0;
      gap();

      // Single write to address 5
      present(16'h8005); drop();
      check("t1_busy_hdr", {31'd0, busy}, 1);
      gap();
      present(16'h1234); exp_we(k, 7'd5, 16'h1234); drop();
      check("t1_busy_end", {31'd0, busy}, 0);
      check("t1_err", {31'd0, err}, 0);
      gap();

      // Three-word read from address 3
      present(16'h0203); exp_rd(k, 7'd3, 16'hA503); drop(); gap();
      present(16'hFFFF); exp_rd(k, 7'd4, 16'hA504); drop(); gap();
      present(16'h0000); exp_rd(k, 7'd5, 16'hA505); drop(); gap();
      check("t2_busy_wait", {31'd0, busy}, 1);
      send(16'h0000);
      check("t2_busy_end", {31'd0, busy}, 0);

      // Two writes starting at the last address, wrapping to 0
      send(16'h8140);
      present(16'h0BAD); exp_we(k, 7'd64, 16'h0BAD); drop(); gap();
      present(16'hF00D); exp_we(k, 7'd0, 16'hF00D); drop();
      check("t3_busy_end", {31'd0, busy}, 0);
      gap();

      // Out-of-range read, out-of-range write, then a valid header clears ERR
      present(16'h0046); exp_rd(k, 7'd0, 16'h0000); void'(q_re.pop_back()); drop();
      check("t4_err_rd", {31'd0, err}, 1);
      gap();
      send(16'h1111);
      send(16'h8050);
      send(16'hCAFE);
      check("t4_err_wr", {31'd0, err}, 1);
      check("t4_busy_err", {31'd0, busy}, 0);
      present(16'h8000); drop();
      check("t4_err_clear", {31'd0, err}, 0);
      gap();
      present(16'h5A5A); exp_we(k, 7'd0, 16'h5A5A); drop(); gap();

      // Abort mid-burst; the word presented with slave-select low is dropped
      send(16'h8302);
      present(16'h1111); exp_we(k, 7'd2, 16'h1111); drop(); gap();
      @(negedge sys_clk);
      ssel_active = 1'b0;
      word_valid  = 1'b1;
      rx_word     = 16'h2222;
      @(negedge sys_clk);
      word_valid  = 1'b0;
      check("t5_busy_abort", {31'd0, busy}, 0);
      ssel_active = 1'b1;
      gap();
      present(16'h0001); exp_rd(k, 7'd1, 16'hA501); drop();
      check("t5_busy_rd", {31'd0, busy}, 1);
      gap();
      send(16'h0000);
      check("t5_busy_end", {31'd0, busy}, 0);

      // Asynchronous reset while in the fetch state
      present(16'h0000); drop();
      sys_rst = 1'b1;
      #1;
      check("t6_busy", {31'd0, busy}, 0);
      check("t6_re", {31'd0, reg_re}, 0);
      check("t6_tx_word", {16'd0, tx_word}, 0);
      check("t6_waddr", {25'd0, reg_waddr}, 0);
      check("t6_wdata", {16'd0, reg_wdata}, 0);
      repeat (3) @(negedge sys_clk);
      sys_rst = 1'b0;
      gap();

      // Normal operation after reset
      send(16'h8007);
      present(16'hBEEF); exp_we(k, 7'd7, 16'hBEEF); drop(); gap();

      gap();
      check("left_we", q_we.size(), 0);
      check("left_re", q_re.size(), 0);
      check("left_tx", q_tx.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
